// File: rtl/port_det_pkg.sv
// Shared types for the port detector: FSM state encoding and the accumulator
// width rule used by the top level and the MAC sub-module.
package port_det_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_ACCUM,
      ST_DONE
   } det_state_t;

   // Room for N full-precision products without overflow.
   function automatic int acc_width(input int data_w, input int lo_w, input int log2_n);
      return data_w + lo_w + log2_n;
   endfunction

endpackage

// File: rtl/port_det_mac.sv
// Single-channel signed multiply-accumulate: acc_next is the running sum
// including the current product, committed to the accumulator when enable is high.
module port_det_mac #(
   parameter int DATA_W = 12,
   parameter int LO_W   = 12,
   parameter int ACC_W  = 28
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     enable,
   input  logic signed [DATA_W-1:0] data,
   input  logic signed [LO_W-1:0]   lo,
   output logic signed [ACC_W-1:0]  acc_next
);

   localparam int PROD_W = DATA_W + LO_W;

   logic signed [PROD_W-1:0] data_ext;
   logic signed [PROD_W-1:0] lo_ext;
   logic signed [PROD_W-1:0] product;
   logic signed [ACC_W-1:0]  product_ext;
   logic signed [ACC_W-1:0]  acc;

   assign data_ext    = {{LO_W{data[DATA_W-1]}}, data};
   assign lo_ext      = {{DATA_W{lo[LO_W-1]}}, lo};
   assign product     = data_ext * lo_ext;
   assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
   assign acc_next    = acc + product_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc_next;
      end
   end

endmodule

// File: rtl/sparam_port_detector.sv
// Coherent I/Q detector for one S-parameter frequency point: settle, correlate N samples, hand off.
// Optional PORT_DET_MAG2_EN adds res_mag2 = res_i^2 + res_q^2 with one extra cycle of latency.
module sparam_port_detector
   import port_det_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int LO_W   = 12,
   parameter int LOG2_N = 4,
   parameter int SETTLE = 2,
   parameter int ACC_W  = acc_width(DATA_W, LO_W, LOG2_N)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     smp_valid,
   input  logic signed [DATA_W-1:0] smp_data,
   input  logic signed [LO_W-1:0]   lo_cos,
   input  logic signed [LO_W-1:0]   lo_sin,
   output logic                     busy,
   output logic                     res_valid,
   input  logic                     res_ready,
`ifdef PORT_DET_MAG2_EN
   output logic [2*ACC_W-1:0]       res_mag2,
`endif
   output logic signed [ACC_W-1:0]  res_i,
   output logic signed [ACC_W-1:0]  res_q
);

   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int CNT_W = (LOG2_N > SET_W) ? LOG2_N : SET_W;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [CNT_W-1:0] ACC_LAST    = CNT_W'((1 << LOG2_N) - 1);
   localparam det_state_t       FIRST_ST    = (SETTLE > 0) ? ST_SETTLE : ST_ACCUM;

   det_state_t              state;
   logic [CNT_W-1:0]        cnt;
   logic                    handshake;
   logic                    launch;
   logic                    take;
   logic signed [ACC_W-1:0] sum_i;
   logic signed [ACC_W-1:0] sum_q;

   // abort outranks start, samples and the output handshake in the same cycle.
   assign handshake = (state == ST_DONE) && res_valid && res_ready;
   assign launch    = !abort && start && ((state == ST_IDLE) || handshake);
   assign take      = !abort && smp_valid && (state == ST_ACCUM);

   port_det_mac #(
      .DATA_W (DATA_W),
      .LO_W   (LO_W),
      .ACC_W  (ACC_W)
   ) u_mac_i (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (launch),
      .enable   (take),
      .data     (smp_data),
      .lo       (lo_cos),
      .acc_next (sum_i)
   );

   port_det_mac #(
      .DATA_W (DATA_W),
      .LO_W   (LO_W),
      .ACC_W  (ACC_W)
   ) u_mac_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (launch),
      .enable   (take),
      .data     (smp_data),
      .lo       (lo_sin),
      .acc_next (sum_q)
   );

`ifdef PORT_DET_MAG2_EN
   logic                      mag_pend;
   logic signed [2*ACC_W-1:0] ext_i;
   logic signed [2*ACC_W-1:0] ext_q;
   logic signed [2*ACC_W-1:0] sq_i;
   logic signed [2*ACC_W-1:0] sq_q;

   assign ext_i = {{ACC_W{res_i[ACC_W-1]}}, res_i};
   assign ext_q = {{ACC_W{res_q[ACC_W-1]}}, res_q};
   assign sq_i  = ext_i * ext_i;
   assign sq_q  = ext_q * ext_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         res_valid <= 1'b0;
         res_i     <= '0;
         res_q     <= '0;
`ifdef PORT_DET_MAG2_EN
         mag_pend  <= 1'b0;
         res_mag2  <= '0;
`endif
      end else if (abort) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         res_valid <= 1'b0;
`ifdef PORT_DET_MAG2_EN
         mag_pend  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  state <= FIRST_ST;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            ST_SETTLE: begin
               if (smp_valid) begin
                  if (cnt == SETTLE_LAST) begin
                     state <= ST_ACCUM;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_ACCUM: begin
               if (take) begin
                  if (cnt == ACC_LAST) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     cnt   <= '0;
                     res_i <= sum_i;
                     res_q <= sum_q;
`ifdef PORT_DET_MAG2_EN
                     mag_pend  <= 1'b1;
`else
                     res_valid <= 1'b1;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
`ifdef PORT_DET_MAG2_EN
               if (mag_pend) begin
                  res_mag2  <= $unsigned(sq_i) + $unsigned(sq_q);
                  res_valid <= 1'b1;
                  mag_pend  <= 1'b0;
               end else
`endif
               if (handshake) begin
                  res_valid <= 1'b0;
                  cnt       <= '0;
                  if (launch) begin
                     state <= FIRST_ST;
                     busy  <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sparam_port_detector.sv
// Randomized scoreboard bench for sparam_port_detector; honours PORT_DET_MAG2_EN
// for the extra magnitude output and its longer latency.
module tb_sparam_port_detector;

   localparam int DATA_W = 12;
   localparam int LO_W   = 12;
   localparam int LOG2_N = 4;
   localparam int SETTLE = 2;
   localparam int ACC_W  = DATA_W + LO_W + LOG2_N;
   localparam int N      = 1 << LOG2_N;
   localparam int TOTAL  = SETTLE + N;
`ifdef PORT_DET_MAG2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     start = 1'b0;
   logic                     abort = 1'b0;
   logic                     smp_valid = 1'b0;
   logic signed [DATA_W-1:0] smp_data = '0;
   logic signed [LO_W-1:0]   lo_cos = '0;
   logic signed [LO_W-1:0]   lo_sin = '0;
   logic                     res_ready = 1'b1;
   logic                     busy;
   logic                     res_valid;
   logic signed [ACC_W-1:0]  res_i;
   logic signed [ACC_W-1:0]  res_q;
`ifdef PORT_DET_MAG2_EN
   logic [2*ACC_W-1:0]       res_mag2;
`endif

   typedef struct {
      longint i;
      longint q;
      int     cyc;
   } exp_t;

   exp_t   exp_q[$];
   exp_t   cur;
   int     errors = 0;
   int     checks = 0;
   int     cyc = 0;
   bit     prev_valid = 1'b0;
   longint last_i = 0;

   sparam_port_detector #(
      .DATA_W (DATA_W),
      .LO_W   (LO_W),
      .LOG2_N (LOG2_N),
      .SETTLE (SETTLE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .smp_valid (smp_valid),
      .smp_data  (smp_data),
      .lo_cos    (lo_cos),
      .lo_sin    (lo_sin),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
`ifdef PORT_DET_MAG2_EN
      .res_mag2  (res_mag2),
`endif
      .res_i     (res_i),
      .res_q     (res_q)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: sum of products over valid samples SETTLE..SETTLE+N-1 of the point.
   task automatic applyStimulus(input int kind, input bit gaps, input bit do_start);
      logic signed [DATA_W-1:0] d[TOTAL];
      logic signed [LO_W-1:0]   c[TOTAL];
      logic signed [LO_W-1:0]   s[TOTAL];
      exp_t e;
      for (int k = 0; k < TOTAL; k++) begin
         case (kind)
            0: begin d[k] = 12'(100);   c[k] = 12'(2047);  s[k] = 12'(0);    end
            1: begin d[k] = 12'(-2048); c[k] = 12'(-2048); s[k] = 12'(2047); end
            default: begin
               d[k] = 12'($urandom);
               c[k] = 12'($urandom);
               s[k] = 12'($urandom);
            end
         endcase
      end
      e.i = 0;
      e.q = 0;
      e.cyc = 0;
      for (int k = SETTLE; k < TOTAL; k++) begin
         e.i += longint'(d[k]) * longint'(c[k]);
         e.q += longint'(d[k]) * longint'(s[k]);
      end
      if (do_start) begin
         start = 1'b1;
         step();
         start = 1'b0;
         checkOutput("busy_after_start", longint'(busy), 1);
      end
      for (int k = 0; k < TOTAL; k++) begin
         if (gaps) begin
            smp_valid = 1'b0;
            smp_data  = 12'($urandom);
            lo_cos    = 12'($urandom);
            lo_sin    = 12'($urandom);
            step();
            checkOutput("busy_during_gap", longint'(busy), 1);
         end
         smp_valid = 1'b1;
         smp_data  = d[k];
         lo_cos    = c[k];
         lo_sin    = s[k];
         if (k == TOTAL - 1) begin
            e.cyc = cyc;
            exp_q.push_back(e);
         end
         step();
      end
      smp_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || res_valid) && n < 100) begin
         step();
         n++;
      end
      checkOutput("drain_within_budget", longint'(n < 100), 1);
      step();
   endtask

   // Monitor: each new result pops the scoreboard; held results must stay put.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (res_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_result: got res_valid=1, expected no result");
            end else begin
               cur = exp_q.pop_front();
               checkOutput("res_i", longint'(res_i), cur.i);
               checkOutput("res_q", longint'(res_q), cur.q);
               checkOutput("latency", longint'(cyc), longint'(cur.cyc + LAT));
`ifdef PORT_DET_MAG2_EN
               checkOutput("res_mag2", longint'(res_mag2), cur.i * cur.i + cur.q * cur.q);
`endif
               last_i = cur.i;
            end
         end else if (res_valid) begin
            checkOutput("hold_res_i", longint'(res_i), cur.i);
            checkOutput("hold_res_q", longint'(res_q), cur.q);
         end
         prev_valid = res_valid;
      end
   end

   initial begin
      int n;
      #12;
      checkOutput("reset_busy", longint'(busy), 0);
      checkOutput("reset_res_valid", longint'(res_valid), 0);
      checkOutput("reset_res_i", longint'(res_i), 0);
      checkOutput("reset_res_q", longint'(res_q), 0);
      rst_n = 1'b1;
      step();
      step();

      applyStimulus(0, 1'b0, 1'b1);
      drain();
      applyStimulus(1, 1'b0, 1'b1);
      drain();
      applyStimulus(2, 1'b1, 1'b1);
      drain();

      // Back-pressure: result must hold, stray starts ignored, then restart with the handshake.
      res_ready = 1'b0;
      applyStimulus(2, 1'b0, 1'b1);
      n = 0;
      while (!res_valid && n < 20) begin
         step();
         n++;
      end
      checkOutput("result_appears", longint'(res_valid), 1);
      for (int k = 0; k < 10; k++) begin
         start = k[0];
         step();
         checkOutput("busy_in_done", longint'(busy), 0);
         checkOutput("valid_held", longint'(res_valid), 1);
      end
      start = 1'b1;
      res_ready = 1'b1;
      step();
      start = 1'b0;
      checkOutput("busy_on_restart", longint'(busy), 1);
      checkOutput("valid_cleared", longint'(res_valid), 0);
      applyStimulus(2, 1'b0, 1'b0);
      drain();

      // Abort after 7 accumulated samples.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < SETTLE + 7; k++) begin
         smp_valid = 1'b1;
         smp_data  = 12'($urandom);
         lo_cos    = 12'($urandom);
         lo_sin    = 12'($urandom);
         step();
      end
      smp_valid = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      checkOutput("abort_busy", longint'(busy), 0);
      checkOutput("abort_res_valid", longint'(res_valid), 0);
      checkOutput("abort_keeps_res_i", longint'(res_i), last_i);
      applyStimulus(2, 1'b0, 1'b1);
      drain();

      for (int r = 0; r < 4; r++) begin
         applyStimulus(2, 1'($urandom_range(0, 1)), 1'b1);
         drain();
      end

      // Asynchronous reset in the middle of accumulation.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         smp_valid = 1'b1;
         smp_data  = 12'($urandom);
         lo_cos    = 12'($urandom);
         lo_sin    = 12'($urandom);
         step();
      end
      smp_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", longint'(busy), 0);
      checkOutput("midreset_res_valid", longint'(res_valid), 0);
      checkOutput("midreset_res_i", longint'(res_i), 0);
      checkOutput("midreset_res_q", longint'(res_q), 0);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) step();
      checkOutput("after_reset_busy", longint'(busy), 0);
      checkOutput("after_reset_no_result", longint'(res_valid), 0);
      checkOutput("scoreboard_empty", longint'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
